// File: rtl/mdu_sequencer.sv
// mdu_sequencer: control sequencer for an iterative shift/add multiplier and
// shift/subtract divider. It accepts one operation and runs a one-cycle operand
// load. It then issues WIDTH step pulses and holds the result valid until the
// consumer takes it.
// Optional feature: define MDU_SEQ_ABORT_EN to add an abort input. This input
// cancels an operation that is in LOAD or RUN.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  output logic             op_q,
  output logic             opnd_load,
  output logic             acc_clear,
  output logic             step_en,
  output logic [CNT_W-1:0] step_idx,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef MDU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_step_idx;
  logic [CNT_W-1:0] w_step_idx_nxt;
  logic             r_op_q;
  logic             w_abort;
  logic             w_last_step;

`ifdef MDU_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last_step = (r_step_idx == CNT_W'(WIDTH - 1));
  assign step_idx    = r_step_idx;
  assign op_q        = r_op_q;

  // State and iteration counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_step_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_idx <= w_step_idx_nxt;
    end
  end

  // Operation select captured only on the accept edge, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q <= 1'b0;
    end else if ((r_state == S_IDLE) && start_valid) begin
      r_op_q <= op;
    end
  end

  // Next-state, next-count and Moore output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_step_idx_nxt = r_step_idx;
    start_ready    = 1'b0;
    opnd_load      = 1'b0;
    acc_clear      = 1'b0;
    step_en        = 1'b0;
    res_valid      = 1'b0;
    busy           = 1'b1;
    case (r_state)
      S_IDLE: begin
        start_ready    = 1'b1;
        busy           = 1'b0;
        w_step_idx_nxt = '0;
        if (start_valid) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_step_idx_nxt = '0;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          opnd_load   = 1'b1;
          acc_clear   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt    = S_IDLE;
          w_step_idx_nxt = '0;
        end else begin
          step_en = 1'b1;
          // The counter returns to zero on the final step, so it never wraps while in RUN.
          if (w_last_step) begin
            w_state_nxt    = S_DONE;
            w_step_idx_nxt = '0;
          end else begin
            w_step_idx_nxt = r_step_idx + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_step_idx_nxt = '0;
      end
    endcase
  end

endmodule
